// File: rtl/freelist_ctrl_4r8w.sv
// rtl/freelist_ctrl_4r8w.sv - circular free-list controller for a 4-read/8-write SRAM
//
// Purpose: keeps head/tail/occupancy of a free list stored in an external SRAM.
// Up to 4 entries are popped (allocated) and up to 8 pushed (released) per cycle.
// Read addresses are always driven (SRAM read is asynchronous); write lanes are
// compacted so the n-th valid push lane goes to write port n.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   pop_cnt_i                  entries requested (0..4, 5..7 treated as 0)
//   pop_grant_o, pop_valid_o   all-or-nothing pop grant, per-slot valid mask
//   rdaddr0_o..rdaddr3_o       SRAM read addresses head+k
//   push_valid_i, push_data_i  release lanes and their data
//   push_accept_o              all-or-nothing push accept
//   wraddr/we/wrdata 0..7      SRAM write ports, addresses tail+m
//   count_o, empty_o, full_o   occupancy status
//   err_o                      sticky under/overflow flag (FREELIST_ERR_CHECK_EN only)
//
// Optional feature macro: FREELIST_ERR_CHECK_EN

module freelist_ctrl_4r8w #(
    parameter int FL_DEPTH = 16,
    parameter int FL_INDEX = 4,
    parameter int FL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            pop_cnt_i,
    output logic                  pop_grant_o,
    output logic [FL_INDEX-1:0]   rdaddr0_o,
    output logic [FL_INDEX-1:0]   rdaddr1_o,
    output logic [FL_INDEX-1:0]   rdaddr2_o,
    output logic [FL_INDEX-1:0]   rdaddr3_o,
    output logic [3:0]            pop_valid_o,
    input  logic [7:0]            push_valid_i,
    input  logic [8*FL_WIDTH-1:0] push_data_i,
    output logic                  push_accept_o,
    output logic [FL_INDEX-1:0]   wraddr0_o,
    output logic [FL_INDEX-1:0]   wraddr1_o,
    output logic [FL_INDEX-1:0]   wraddr2_o,
    output logic [FL_INDEX-1:0]   wraddr3_o,
    output logic [FL_INDEX-1:0]   wraddr4_o,
    output logic [FL_INDEX-1:0]   wraddr5_o,
    output logic [FL_INDEX-1:0]   wraddr6_o,
    output logic [FL_INDEX-1:0]   wraddr7_o,
    output logic                  we0_o,
    output logic                  we1_o,
    output logic                  we2_o,
    output logic                  we3_o,
    output logic                  we4_o,
    output logic                  we5_o,
    output logic                  we6_o,
    output logic                  we7_o,
    output logic [FL_WIDTH-1:0]   wrdata0_o,
    output logic [FL_WIDTH-1:0]   wrdata1_o,
    output logic [FL_WIDTH-1:0]   wrdata2_o,
    output logic [FL_WIDTH-1:0]   wrdata3_o,
    output logic [FL_WIDTH-1:0]   wrdata4_o,
    output logic [FL_WIDTH-1:0]   wrdata5_o,
    output logic [FL_WIDTH-1:0]   wrdata6_o,
    output logic [FL_WIDTH-1:0]   wrdata7_o,
    output logic [FL_INDEX:0]     count_o,
    output logic                  empty_o,
    output logic                  full_o
`ifdef FREELIST_ERR_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    localparam int CNTW = FL_INDEX + 1;
    // One extra bit so depth - count + popped cannot wrap.
    localparam int SPW  = FL_INDEX + 2;

    logic [FL_INDEX-1:0] head_q, head_d;
    logic [FL_INDEX-1:0] tail_q, tail_d;
    logic [CNTW-1:0]     count_q, count_d;

    logic [2:0]          pop_n;
    logic [3:0]          npush;
    logic [3:0]          slot;
    logic                grant;
    logic                accept;
    logic [SPW-1:0]      space;
    logic [FL_WIDTH-1:0] cdata [8];
    logic [7:0]          we;

    always_comb begin
        // Out-of-range requests behave as no request.
        pop_n = (pop_cnt_i <= 3'd4) ? pop_cnt_i : 3'd0;

        npush = '0;
        for (int j = 0; j < 8; j++) begin
            npush = npush + {3'b000, push_valid_i[j]};
        end

        grant = reset && (pop_n != 3'd0) && (count_q >= CNTW'(pop_n));

        // Entries popped this cycle free their slots for writes landing at the same edge.
        space  = SPW'(FL_DEPTH) - SPW'(count_q) + (grant ? SPW'(pop_n) : '0);
        accept = reset && (npush != 4'd0) && (SPW'(npush) <= space);

        // Compaction: walk lanes LSB first, packing valid data onto consecutive ports.
        slot = '0;
        for (int j = 0; j < 8; j++) begin
            cdata[j] = '0;
        end
        for (int j = 0; j < 8; j++) begin
            if (push_valid_i[j]) begin
                cdata[slot[2:0]] = push_data_i[j*FL_WIDTH +: FL_WIDTH];
                slot = slot + 4'd1;
            end
        end

        for (int m = 0; m < 8; m++) begin
            we[m] = accept && (4'(m) < npush);
        end

        head_d  = head_q + (grant ? FL_INDEX'(pop_n) : '0);
        tail_d  = tail_q + (accept ? FL_INDEX'(npush) : '0);
        count_d = count_q - (grant ? CNTW'(pop_n) : '0) + (accept ? CNTW'(npush) : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef FREELIST_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (((pop_n != 3'd0) && !grant) || ((npush != 4'd0) && !accept)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign pop_grant_o   = grant;
    assign pop_valid_o   = grant ? 4'((5'd1 << pop_n) - 5'd1) : 4'd0;
    assign push_accept_o = accept;

    assign rdaddr0_o = head_q;
    assign rdaddr1_o = head_q + FL_INDEX'(1);
    assign rdaddr2_o = head_q + FL_INDEX'(2);
    assign rdaddr3_o = head_q + FL_INDEX'(3);

    assign wraddr0_o = tail_q;
    assign wraddr1_o = tail_q + FL_INDEX'(1);
    assign wraddr2_o = tail_q + FL_INDEX'(2);
    assign wraddr3_o = tail_q + FL_INDEX'(3);
    assign wraddr4_o = tail_q + FL_INDEX'(4);
    assign wraddr5_o = tail_q + FL_INDEX'(5);
    assign wraddr6_o = tail_q + FL_INDEX'(6);
    assign wraddr7_o = tail_q + FL_INDEX'(7);

    assign we0_o = we[0];
    assign we1_o = we[1];
    assign we2_o = we[2];
    assign we3_o = we[3];
    assign we4_o = we[4];
    assign we5_o = we[5];
    assign we6_o = we[6];
    assign we7_o = we[7];

    assign wrdata0_o = cdata[0];
    assign wrdata1_o = cdata[1];
    assign wrdata2_o = cdata[2];
    assign wrdata3_o = cdata[3];
    assign wrdata4_o = cdata[4];
    assign wrdata5_o = cdata[5];
    assign wrdata6_o = cdata[6];
    assign wrdata7_o = cdata[7];

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNTW'(FL_DEPTH));

endmodule
